// File: rtl/rv32_boot_loader.sv
// Framed byte-stream loader: assembles little-endian words into instruction memory
// and holds the core in reset until the whole image has loaded with a matching checksum.
module rv32_boot_loader #(
  parameter int unsigned IMEM_DEPTH_WORDS = 256,
  parameter int unsigned ADDR_W           = 8,
  parameter logic [7:0]  MAGIC            = 8'hA5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned LEN_W  = 16;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_RUN,
    S_ERR
  } state_t;

  state_t              state, state_nxt;
  logic [LEN_W-1:0]    len_q, len_nxt;
  logic [LEN_W-1:0]    len_full;
  logic [ADDR_W-1:0]   idx_q, idx_nxt;
  logic [1:0]          bcnt_q, bcnt_nxt;
  logic [23:0]         word_q, word_nxt;
  logic [7:0]          xsum_q, xsum_nxt;
  logic                we_q, we_nxt;
  logic [ADDR_W-1:0]   addr_q, addr_nxt;
  logic [WORD_W-1:0]   wdata_q, wdata_nxt;
  logic                accept;

  // Status outputs are pure decodes of the state register.
  assign rx_ready   = (state != S_RUN) && (state != S_ERR);
  assign busy       = rx_ready && (state != S_IDLE);
  assign done       = (state == S_RUN);
  assign error      = (state == S_ERR);
  assign cpu_reset  = (state != S_RUN);
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

  assign accept = rx_valid && rx_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      xsum_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_nxt;
      len_q   <= len_nxt;
      idx_q   <= idx_nxt;
      bcnt_q  <= bcnt_nxt;
      word_q  <= word_nxt;
      xsum_q  <= xsum_nxt;
      we_q    <= we_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    len_nxt   = len_q;
    len_full  = {rx_data, len_q[7:0]};
    idx_nxt   = idx_q;
    bcnt_nxt  = bcnt_q;
    word_nxt  = word_q;
    xsum_nxt  = xsum_q;
    we_nxt    = 1'b0;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;

    case (state)
      S_IDLE: begin
        if (accept && (rx_data == MAGIC)) begin
          state_nxt = S_LEN_LO;
          xsum_nxt  = '0;
          idx_nxt   = '0;
          bcnt_nxt  = '0;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_nxt   = {8'h00, rx_data};
          state_nxt = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_nxt = len_full;
          if (len_full > LEN_W'(IMEM_DEPTH_WORDS)) begin
            state_nxt = S_ERR;
          end else if (len_full == '0) begin
            state_nxt = S_CHECK;
          end else begin
            state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          xsum_nxt = xsum_q ^ rx_data;
          bcnt_nxt = bcnt_q + 2'd1;
          case (bcnt_q)
            2'd0: word_nxt[7:0]   = rx_data;
            2'd1: word_nxt[15:8]  = rx_data;
            2'd2: word_nxt[23:16] = rx_data;
            default: begin
              // Fourth byte completes the word; the write is issued next cycle.
              we_nxt    = 1'b1;
              addr_nxt  = idx_q;
              wdata_nxt = {rx_data, word_q};
              idx_nxt   = idx_q + ADDR_W'(1);
              if (LEN_W'(idx_q) == (len_q - LEN_W'(1))) begin
                state_nxt = S_CHECK;
              end
            end
          endcase
        end
      end
      S_CHECK: begin
        if (accept) begin
          state_nxt = (rx_data == xsum_q) ? S_RUN : S_ERR;
        end
      end
      S_RUN:   state_nxt = S_RUN;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rv32_boot_loader.sv
// Scoreboard bench for rv32_boot_loader: a frame-level reference model predicts writes
// and final status; a forked monitor checks every imem write against the expected queue.
module tb_rv32_boot_loader;

  localparam logic [7:0]  MAGIC = 8'hA5;
  localparam int unsigned DEPTH = 256;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;

  wr_t exp_q[$];
  int  n_pass;
  int  n_total;

  rv32_boot_loader #(
    .IMEM_DEPTH_WORDS(DEPTH),
    .ADDR_W(8),
    .MAGIC(MAGIC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset),
    .busy(busy),
    .done(done),
    .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Reference model: parse the frame by its layout and predict writes and outcome.
  task automatic model(input byte_q_t b, output bit exp_done, output bit exp_err);
    int i;
    int n;
    logic [7:0] x;
    wr_t w;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    i = 0;
    x = 8'h00;
    while (i < b.size() && b[i] != MAGIC) i++;
    if (i + 3 > b.size()) return;
    n = int'(b[i+1]) + 256 * int'(b[i+2]);
    i += 3;
    if (n > int'(DEPTH)) begin
      exp_err = 1'b1;
      return;
    end
    for (int k = 0; k < n; k++) begin
      if (i + 4 > b.size()) return;
      w.addr = 8'(k);
      w.data = {b[i+3], b[i+2], b[i+1], b[i]};
      exp_q.push_back(w);
      x = x ^ b[i] ^ b[i+1] ^ b[i+2] ^ b[i+3];
      i += 4;
    end
    if (i < b.size()) begin
      if (b[i] == x) exp_done = 1'b1;
      else exp_err = 1'b1;
    end
  endtask

  task automatic monitor();
    logic prev_we;
    wr_t  w;
    prev_we = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && imem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_write: got addr %h data %h want no write", imem_addr, imem_wdata);
        end else begin
          w = exp_q.pop_front();
          chk("write_addr", 32'(imem_addr), 32'(w.addr));
          chk("write_data", imem_wdata, w.data);
          chk("we_pulse_width", 32'(prev_we), 32'd0);
          chk("cpu_reset_at_write", 32'(cpu_reset), 32'd1);
        end
      end
      prev_we = (reset_n === 1'b1) ? imem_we : 1'b0;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
    chk({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    chk({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
  endtask

  task automatic apply_reset();
    rx_valid = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b, input bit throttle);
    if (throttle) begin
      repeat ($urandom_range(0, 3)) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    rx_data  = b;
    rx_valid = 1'b1;
    if (rx_ready !== 1'b1) begin
      n_total++;
      $display("FAIL rx_ready_stall: got %b want 1 (byte %h dropped)", rx_ready, b);
    end
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input byte_q_t b, input bit throttle);
    foreach (b[i]) send_byte(b[i], throttle);
  endtask

  task automatic finish_frame(input string tag, input bit ed, input bit ee);
    int budget;
    chk({tag, "_done"}, 32'(done), 32'(ed));
    chk({tag, "_error"}, 32'(error), 32'(ee));
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(!ed));
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'(!(ed || ee)));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    budget = 8;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk({tag, "_writes_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    byte_q_t nom;
    byte_q_t f;
    bit ed;
    bit ee;
    int viol;
    int n;
    logic [7:0] x;
    logic [7:0] b;

    n_pass   = 0;
    n_total  = 0;
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    nom = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00,
            8'h93, 8'h00, 8'h20, 8'h00, 8'hB0};

    fork
      monitor();
    join_none

    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Nominal back-to-back load.
    model(nom, ed, ee);
    send_frame(nom, 1'b0);
    finish_frame("nominal", ed, ee);

    // Bad checksum, then status must hold.
    apply_reset();
    f = nom;
    f[11] = 8'hB1;
    model(f, ed, ee);
    send_frame(f, 1'b0);
    finish_frame("badchk", ed, ee);
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (error !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0 || rx_ready !== 1'b0) viol++;
    end
    chk("badchk_hold_violations", 32'(viol), 32'd0);

    // Leading garbage followed by an empty image.
    apply_reset();
    f = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h00, 8'h00, 8'h00};
    model(f, ed, ee);
    foreach (f[i]) begin
      send_byte(f[i], 1'b0);
      if (i < 3) chk("garbage_busy", 32'(busy), 32'd0);
    end
    finish_frame("empty", ed, ee);

    // Oversize length.
    apply_reset();
    f = '{8'hA5, 8'h01, 8'h01};
    model(f, ed, ee);
    send_frame(f, 1'b0);
    finish_frame("oversize", ed, ee);

    // Throttled source.
    apply_reset();
    model(nom, ed, ee);
    send_frame(nom, 1'b1);
    finish_frame("throttled", ed, ee);

    // Reset in the middle of the payload, then a full reload.
    apply_reset();
    f = nom[0:8];
    model(f, ed, ee);
    send_frame(f, 1'b0);
    chk("midrst_pre_writes", 32'(exp_q.size()), 32'd0);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("midrst_async");
    @(negedge clk);
    check_reset_vals("midrst_held");
    reset_n = 1'b1;
    @(negedge clk);
    model(nom, ed, ee);
    send_frame(nom, 1'b0);
    finish_frame("reload", ed, ee);

    // Random images: first one fills memory exactly, later ones are small.
    for (int it = 0; it < 5; it++) begin
      apply_reset();
      n = (it == 0) ? int'(DEPTH) : int'($urandom_range(1, 6));
      f = '{MAGIC, 8'(n), 8'(n >> 8)};
      x = 8'h00;
      for (int k = 0; k < 4 * n; k++) begin
        b = 8'($urandom);
        f.push_back(b);
        x ^= b;
      end
      f.push_back(($urandom_range(0, 1) == 1 && it != 0) ? (x ^ 8'h5A) : x);
      model(f, ed, ee);
      send_frame(f, (it % 2) == 1);
      finish_frame("random", ed, ee);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rv32_boot_loader.md
# rv32_boot_loader

Byte-stream program loader sitting directly upstream of `rv32_single_cycle`. It accepts a framed byte stream on a valid/ready interface and assembles little-endian 32-bit words. It writes those words into the core's instruction memory and holds the core in reset until the whole image has loaded and passed its checksum. It replaces preloaded memory images for bring-up and bench runs.

## Interface
- `IMEM_DEPTH_WORDS`, 256, instruction memory capacity in 32-bit words
- `ADDR_W`, 8, word-address width; must satisfy 2^ADDR_W >= IMEM_DEPTH_WORDS
- `MAGIC`, 8'hA5, frame start byte
- `clk`  in  1  single clock; all state changes on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `rx_data`  in  8  incoming byte
- `rx_valid`  in  1  `rx_data` valid
- `rx_ready`  out  1  loader can accept a byte; a byte transfers on a rising edge with `rx_valid && rx_ready`
- `imem_we`  out  1  one-cycle instruction-memory write strobe
- `imem_addr`  out  ADDR_W  word address of the write
- `imem_wdata`  out  32  write data
- `cpu_reset`  out  1  active-high reset to the core
- `busy`  out  1  frame in progress
- `done`  out  1  image loaded, core released
- `error`  out  1  frame rejected; sticky

## Operation
- Frame layout:
  - `MAGIC`
  - LEN_LO, LEN_HI: 16-bit word count N
  - 4*N payload bytes, little-endian per word, word 0 first
  - CHK: XOR of all payload bytes
- States:
  - IDLE: accepts a byte; `MAGIC` -> LEN_LO; any other byte is dropped and state stays IDLE.
  - LEN_LO: accepts a byte -> LEN_HI.
  - LEN_HI: N > `IMEM_DEPTH_WORDS` -> ERR; N == 0 -> CHECK; otherwise -> DATA.
  - DATA: the byte counter counts 0..3 and shifts each byte into the word register at bits [8k+7:8k]. The 4th byte schedules a write. After word N-1 -> CHECK.
  - CHECK: accepts one byte. Byte equal to the running XOR -> RUN; otherwise -> ERR.
  - RUN: terminal. `cpu_reset`=0, `done`=1, `rx_ready`=0.
  - ERR: terminal. `error`=1, `cpu_reset`=1, `rx_ready`=0. Only `reset_n` leaves RUN or ERR.
- `rx_ready` is decoded from state: 1 in IDLE, LEN_LO, LEN_HI, DATA, CHECK.
- `busy`=1 in LEN_LO, LEN_HI, DATA, CHECK.
- The running XOR and the word index clear when `MAGIC` is accepted.
- Each `imem_addr` = word index. The index increments after each write. N is limited to the memory depth, so the index never wraps.
- N == 0 is a legal empty image. CHK must be 8'h00, and the core is released with memory untouched.

## Timing
- Reset values while `reset_n`=0:
  - state IDLE
  - `rx_ready`=1 (no transfer is possible without a clock edge)
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0
  - `cpu_reset`=1
  - `busy`=0, `done`=0, `error`=0
  - word index, byte counter and XOR = 0
- Reset mid-frame aborts immediately and asynchronously; a partial word is never written. The next frame loads from address 0.
- Write latency: `imem_we` pulses high for exactly one cycle, on the cycle after the 4th byte of a word is accepted. `imem_addr` and `imem_wdata` are registered and valid in that same cycle.
- One byte per cycle at most. Back-to-back bytes give one write every 4 cycles. `rx_valid` gaps stall without penalty.
- CHK may be accepted in the same cycle as the final write strobe. `cpu_reset` and `done` change on the edge after CHK is accepted, so the last write always completes before the core leaves reset.
- ERR is entered on the edge after the offending LEN_HI or CHK byte is accepted. `rx_ready` drops in the same cycle.
- `cpu_reset` never returns to 1 after release except via `reset_n`.

## Test plan
- Nominal load, back-to-back bytes: A5 02 00 13 00 10 00 93 00 20 00 B0 -> writes (addr 0, 32'h00100013) then (addr 1, 32'h00200093), one cycle each. `cpu_reset` falls and `done`=1 on the cycle after B0. `rx_ready`=0 afterwards.
- Bad checksum: same frame ending in B1 -> both writes occur. Then `error`=1, `cpu_reset` stays 1, `done`=0 and `rx_ready`=0, all held for 100 cycles.
- Leading garbage and empty image: 00 FF 13 A5 00 00 00 -> garbage produces no write and `busy` stays 0. The frame gives `done`=1 with zero `imem_we` pulses.
- Oversize length: A5 01 01 -> `error`=1 on the edge after 01 is accepted; no writes.
- Throttled source: the nominal frame with `rx_valid` low on random cycles -> identical writes and checksum result. No byte is lost or duplicated.
- Reset mid-DATA: `reset_n` pulses low after 6 payload bytes, then the nominal frame is sent:
  - during reset, outputs are at their reset values
  - words are rewritten from addr 0
  - `done`=1
